guia_04_tt_scan: RTL and testbench

GUIA_04_TT_SCAN -- requirements
Module: guia_04_tt_scan

---
 rtl/guia_04_tt_scan.sv | 78 +++++++
 tb/tb_guia_04_tt_scan.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/guia_04_tt_scan.sv
// guia_04_tt_scan: scans the four {x,y} rows through five two-input functions and checks their truth tables
module guia_04_tt_scan (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  s_in,
  output logic        x,
  output logic        y,
  output logic        busy,
  output logic        done,
  output logic [19:0] tt_out,
  output logic [4:0]  err_mask,
  output logic        pass
);
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
  localparam logic [19:0] EXP_TT = 20'h6FCE2;
  state_t      r_state, w_next;
  logic [1:0]  r_row, w_row_next;
  logic [1:0]  r_xy;
  logic [19:0] r_shadow, w_shadow_next;
  logic [19:0] r_tt;
  logic [4:0]  r_err, w_err;
  logic        r_pass;
  logic        w_last;
  assign w_last = (r_state == SAMPLE) && (r_row == 2'd3);
  always_comb begin
    w_next = r_state;
    w_row_next = r_row;
    case (r_state)
      IDLE: begin
        w_next = start ? APPLY : IDLE;
        w_row_next = 2'd0;
      end
      APPLY: w_next = SAMPLE;
      SAMPLE: begin
        w_next = (r_row == 2'd3) ? DONE : APPLY;
        w_row_next = (r_row == 2'd3) ? r_row : r_row + 2'd1;
      end
      default: w_next = IDLE;
    endcase
  end
  // the table committed on the last SAMPLE edge must already include row 3
  always_comb begin
    w_shadow_next = r_shadow;
    if (r_state == SAMPLE)
      for (int k = 0; k < 5; k++) w_shadow_next[4*k + int'(r_row)] = s_in[k];
    w_err = '0;
    for (int k = 0; k < 5; k++) w_err[k] = w_shadow_next[4*k +: 4] != EXP_TT[4*k +: 4];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_row    <= 2'd0;
      r_xy     <= 2'd0;
      r_shadow <= '0;
      r_tt     <= '0;
      r_err    <= '0;
      r_pass   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_row    <= w_row_next;
      r_xy     <= (w_next == APPLY || w_next == SAMPLE) ? w_row_next : 2'd0;
      r_shadow <= w_shadow_next;
      if (w_last) begin
        r_tt   <= w_shadow_next;
        r_err  <= w_err;
        r_pass <= ~|w_err;
      end
    end
  end
  assign x        = r_xy[1];
  assign y        = r_xy[0];
  assign busy     = (r_state == APPLY) || (r_state == SAMPLE);
  assign done     = r_state == DONE;
  assign tt_out   = r_tt;
  assign err_mask = r_err;
  assign pass     = r_pass;
endmodule

// File: tb/tb_guia_04_tt_scan.sv
// tb_guia_04_tt_scan: scoreboard bench driving modelled (possibly faulty) functions behind s_in
module tb_guia_04_tt_scan;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [4:0]  s_in;
  logic        x, y, busy, done, pass;
  logic [19:0] tt_out;
  logic [4:0]  err_mask;
  logic [19:0] tbl;
  typedef struct {
    int          st;
    logic [19:0] tt;
    logic [4:0]  err;
    logic        ps;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  int   cyc = 0, next_ok = 0, rst_cyc = -1, cmp = 0, bad = 0;
  bit   armed = 0;
  logic [3:0] spec_tbl [5] = '{4'b0010, 4'b1110, 4'b1100, 4'b1111, 4'b0110};

  guia_04_tt_scan dut (
    .clk(clk), .reset(reset), .start(start), .s_in(s_in),
    .x(x), .y(y), .busy(busy), .done(done),
    .tt_out(tt_out), .err_mask(err_mask), .pass(pass)
  );

  always #5 clk = ~clk;

  always_comb begin
    s_in = '0;
    for (int k = 0; k < 5; k++) s_in[k] = tbl[4*k + int'({x, y})];
  end

  function automatic logic [19:0] golden();
    logic [19:0] g;
    logic xx, yy;
    g = '0;
    for (int r = 0; r < 4; r++) begin
      xx = (r >= 2);
      yy = (r % 2 == 1);
      g[r]      = ~xx & yy;
      g[4 + r]  = xx | yy;
      g[8 + r]  = xx;
      g[12 + r] = 1'b1;
      g[16 + r] = xx ^ yy;
    end
    return g;
  endfunction

  function automatic exp_t model(int st, logic [19:0] t);
    exp_t e;
    e.st = st;
    e.tt = t;
    for (int k = 0; k < 5; k++) e.err[k] = t[4*k +: 4] != spec_tbl[k];
    e.ps = (e.err == 5'd0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      next_ok = cyc + 1;
      rst_cyc = cyc;
      armed = 1;
    end else if (start && cyc >= next_ok) begin
      q.push_back(model(cyc, tbl));
      next_ok = cyc + 10;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      bit   in_scan, exp_done;
      logic [1:0] exp_xy;
      exp_t e;
      if (cyc == rst_cyc) cur = '{0, 20'd0, 5'd0, 1'b0};
      in_scan  = q.size() > 0 && cyc >= q[0].st && cyc <= q[0].st + 7;
      exp_done = q.size() > 0 && cyc == q[0].st + 8;
      exp_xy   = in_scan ? 2'((cyc - q[0].st) / 2) : 2'd0;
      chk("busy", busy, in_scan);
      chk("xy", {x, y}, exp_xy);
      chk("done", done, exp_done);
      if (exp_done) begin
        e = q.pop_front();
        chk("tt_out", tt_out, e.tt);
        chk("err_mask", err_mask, e.err);
        chk("pass", pass, e.ps);
        cur = e;
      end else begin
        chk("hold", {tt_out, err_mask, pass}, {cur.tt, cur.err, cur.ps});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scan_pulse();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (11) step();
  endtask

  initial begin
    logic [19:0] t;
    reset = 1'b1;
    start = 1'b0;
    tbl = golden();
    repeat (2) step();
    chk("rst_tt", tt_out, 20'd0);
    chk("rst_pass", pass, 1'b0);
    reset = 1'b0;
    scan_pulse();
    chk("clean_tt", tt_out, 20'h6FCE2);
    chk("clean_pass", pass, 1'b1);
    tbl[19:16] = 4'b0000;
    scan_pulse();
    chk("e0_tt", tt_out[19:16], 4'b0000);
    chk("e0_err", err_mask, 5'b10000);
    tbl = golden();
    tbl[7:4] = 4'b1000;
    scan_pulse();
    chk("band_tt", tt_out[7:4], 4'b1000);
    chk("band_err", err_mask, 5'b00010);
    tbl = golden();
    scan_pulse();
    tbl[3:0] = 4'b0000;
    scan_pulse();
    chk("fault_pass", pass, 1'b0);
    tbl = golden();
    scan_pulse();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_tt", tt_out, 20'd0);
    chk("abort_pass", pass, 1'b0);
    repeat (10) step();
    scan_pulse();
    chk("after_abort_pass", pass, 1'b1);
    start = 1'b1;
    repeat (20) step();
    start = 1'b0;
    repeat (12) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    for (int i = 0; i < 2000; i++) begin
      step();
      reset = ($urandom_range(0, 79) == 0);
      if (q.size() == 0 && !start) begin
        case ($urandom_range(0, 2))
          0: t = golden();
          1: t = golden() ^ (20'd1 << $urandom_range(0, 19));
          default: t = 20'($urandom);
        endcase
        tbl = t;
      end
      start = ($urandom_range(0, 3) == 0);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (12) step();
    chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
